test_monitor: RTL

TEST_MONITOR -- requirements
Module: test_monitor

---
 rtl/test_monitor.sv | 66 ++++++
 1 files changed

// File: rtl/test_monitor.sv
// test_monitor: watches CPU stores for a pass signature or a timeout; define TEST_MONITOR_STRICT_EN to fail on wrong data at a signature address.
module test_monitor #(
  parameter int TIMEOUT = 512,
  parameter logic [63:0] SIG0_ADR = 64'd84,
  parameter logic [63:0] SIG0_DAT = 64'd7,
  parameter logic [63:0] SIG1_ADR = 64'd128,
  parameter logic [63:0] SIG1_DAT = 64'd7,
  parameter logic [63:0] SIG2_ADR = 64'd80,
  parameter logic [63:0] SIG2_DAT = 64'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  memwrite,
  input  logic [63:0] dataadr,
  input  logic [63:0] writedata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [1:0]  pass_id,
  output logic [15:0] cycles,
  output logic [15:0] wr_count
);
  typedef enum logic [1:0] {RUN, PASS, FAIL} state_t;
  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
  state_t state;
  logic wr, m0, m1, m2, hit, strict_fail;
  logic [1:0] id;
  assign wr = |memwrite;
  assign m0 = wr && dataadr == SIG0_ADR && writedata == SIG0_DAT;
  assign m1 = wr && dataadr == SIG1_ADR && writedata == SIG1_DAT;
  assign m2 = wr && dataadr == SIG2_ADR && writedata == SIG2_DAT;
  assign hit = m0 | m1 | m2;
  assign id = m0 ? 2'd0 : m1 ? 2'd1 : m2 ? 2'd2 : 2'd3;
`ifdef TEST_MONITOR_STRICT_EN
  logic adr_hit;
  assign adr_hit = wr && (dataadr == SIG0_ADR || dataadr == SIG1_ADR || dataadr == SIG2_ADR);
  assign strict_fail = adr_hit && !hit;
`else
  assign strict_fail = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      pass_id  <= 2'd3;
      cycles   <= '0;
      wr_count <= '0;
    end else if (state == RUN) begin
      cycles   <= cycles + 16'(cycles != 16'hFFFF);
      wr_count <= wr_count + 16'(wr && wr_count != 16'hFFFF);
      // a match outranks both timeout and strict mismatch on the same edge
      if (hit) begin
        state   <= PASS;
        done    <= 1'b1;
        pass    <= 1'b1;
        pass_id <= id;
      end else if (cycles == LAST || strict_fail) begin
        state <= FAIL;
        done  <= 1'b1;
        fail  <= 1'b1;
      end
    end
  end
endmodule
